issue_queue_ctrl: RTL and testbench
===================================

Name: issue_queue_ctrl

Overview:
- Dual-issue scheduler between the id1 decode stages and the two issue_id2 pipeline registers.
- Buffers up to DEPTH decoded instructions in program order and accepts up to two per cycle from id1.
- Each cycle it selects zero, one or two head entries for issue slots 0 and 1, applying pairing and hazard rules.
- Drives the valid and stall inputs of both issue_id2 instances and back-pressures id1.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush (branch mispredict or exception); empties the queue.
- stall  in  1  downstream stall; no entry leaves the queue.
- in0_valid  in  1  id1 slot 0 entry valid.
- in0_entry  in  ENTRY_W  slot 0 packed entry (layout in package).
- in1_valid  in  1  id1 slot 1 entry valid; program-order younger than slot 0.
- in1_entry  in  ENTRY_W  slot 1 packed entry.
- in_ready  out  1  at least 2 free entries; id1 may present this cycle.
- iss0_valid  out  1  slot 0 issues this cycle.
- iss0_entry  out  ENTRY_W  oldest queue entry.
- iss1_valid  out  1  slot 1 issues this cycle.
- iss1_entry  out  ENTRY_W  second-oldest queue entry.
- q_count  out  PTR_W+1  current occupancy.

Behaviour:
- Storage: circular buffer with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- Reset: head, tail and count are 0; storage contents are don't-care.
  - Reset outputs: in_ready=1, iss0_valid=0, iss1_valid=0, q_count=0.
  - iss*_entry is all-zero whenever the matching valid is 0.
- Enqueue when in_ready and in0_valid:
  - in0_entry is written at tail.
  - in1_entry is written at tail+1 if in1_valid.
  - Tail advances by 1 or 2.
- in1_valid without in0_valid is ignored; nothing is written.
- Enqueued data is visible at the head on the next cycle; there is no bypass.
- Issue selection is combinational from the head, and iss*_entry is read directly from storage.
  - iss0_valid = count>=1 and !stall and !flush and branch-hold not active.
  - Branch hold: head entry has is_branch, is_j_imme or is_jr, and count<2. The branch waits until its delay slot is queued, and they issue together.
  - iss1_valid = iss0_valid and count>=2 and none of the following:
    - a) RAW: e0.w_reg_ena and e0.w_reg_dst!=0 and e0.w_reg_dst equals e1.rs or e1.rt.
    - b) WAW: both w_reg_ena with equal nonzero dst.
    - c) both is_ls (single memory port).
    - d) e1 is a branch or jump (a branch never sits in slot 1).
  - Exception to the rules above: when e0 is a branch or jump, slot 1 holding its delay slot issues regardless of c). A RAW/WAW hazard between branch and delay slot still applies. In that case both slots stall for one cycle and then the pair issues together; it is never split.
- Dequeue: head advances by iss0_valid+iss1_valid.
- Count update: count_next = count + enq_n - deq_n, with enqueue and dequeue in the same cycle allowed.
- in_ready = (DEPTH - count) >= 2, registered-state based. It does not depend on this cycle's dequeue.
- Flush has the highest priority after rst:
  - head=tail=count=0 on the next edge, and the same-cycle enqueue is dropped.
  - Both iss*_valid are forced to 0 in the flush cycle.
- The issue_id2 registers are driven with id1_valid_o = iss*_valid. Invalid slots are therefore latched as bubbles.
- Full: count=DEPTH-1 or DEPTH leaves in_ready=0, and no write occurs even if the valids are asserted.
- Empty: both valids are 0.

Decomposition:
- Package gemini_issue_pkg defines ENTRY_W=112 and the field offsets, MSB to LSB:
  - pc[31:0], inst[31:0], imme[15:0], rs[4:0], rt[4:0], w_reg_dst[4:0], op_code[5:0], w_reg_ena, is_branch, is_j_imme, is_jr, is_ls.
  - It also provides functions is_ctrl(entry) and dual_hazard(e0,e1).
- One sub-module, issue_pair_check: combinational hazard and pairing logic. Inputs are e0, e1 and count; outputs are iss0_ok and iss1_ok.
- Storage and pointers stay in the top module.

Test Plan:
- Reset, then enqueue two independent ALU ops (addu r1; addu r2 with sources r3,r4) -> next cycle q_count=2, iss0_valid=1, iss1_valid=1, following cycle q_count=0.
- RAW pair (addu r5 <= ...; subu with rs=r5) -> cycle 1: iss0=1, iss1=0; cycle 2: subu issues in slot 0.
- Two loads (lw, lw) -> issued serially, one per cycle; never iss1_valid=1.
- Branch alone (beq, in1_valid=0), then delay-slot ALU op enqueued two cycles later:
  - iss0_valid=0 while count=1.
  - beq and delay slot issue together the cycle after the second enqueue.
- Fill with stall=1 by presenting pairs until in_ready=0 at count=7 -> no further writes. Then stall=0 drains pairs, and the pointers wrap past index 7 with entries in correct order.
- flush asserted at count=5 with in0_valid=1 -> iss*_valid=0 that cycle; next cycle q_count=0 and in_ready=1, and the dropped entry never issues.

Source files
------------

// File: rtl/gemini_issue_pkg.sv
// rtl/gemini_issue_pkg.sv - entry layout and pairing helpers shared by the issue queue
// Entry fields, MSB to LSB: pc, inst, imme, rs, rt, w_reg_dst, op_code,
// w_reg_ena, is_branch, is_j_imme, is_jr, is_ls, then 6 pad bits.
package gemini_issue_pkg;

  localparam int ENTRY_W = 112;

  localparam int PC_LSB     = 80;
  localparam int INST_LSB   = 48;
  localparam int IMME_LSB   = 32;
  localparam int RS_LSB     = 27;
  localparam int RT_LSB     = 22;
  localparam int DST_LSB    = 17;
  localparam int OPCODE_LSB = 11;
  localparam int WENA_BIT   = 10;
  localparam int BRANCH_BIT = 9;
  localparam int JIMME_BIT  = 8;
  localparam int JR_BIT     = 7;
  localparam int LS_BIT     = 6;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] imme;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  w_reg_dst;
    logic [5:0]  op_code;
    logic        w_reg_ena;
    logic        is_branch;
    logic        is_j_imme;
    logic        is_jr;
    logic        is_ls;
    logic [5:0]  pad;
  } entry_t;

  function automatic logic is_ctrl(entry_t e);
    return e.is_branch | e.is_j_imme | e.is_jr;
  endfunction

  // RAW or WAW of e1 against the register e0 writes; r0 never creates a hazard
  function automatic logic dual_hazard(entry_t e0, entry_t e1);
    logic writes;
    logic raw;
    logic waw;
    writes = e0.w_reg_ena && (e0.w_reg_dst != 5'd0);
    raw    = writes && ((e0.w_reg_dst == e1.rs) || (e0.w_reg_dst == e1.rt));
    waw    = writes && e1.w_reg_ena && (e0.w_reg_dst == e1.w_reg_dst);
    return raw | waw;
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// rtl/issue_pair_check.sv - combinational pairing rules for the two head entries
// e0, e1   : oldest and second-oldest queue entries (e1 meaningless when count<2)
// count    : queue occupancy
// iss0_ok  : head may issue (ignores stall/flush and the branch-pair hazard wait)
// iss1_ok  : second entry may issue alongside the head
module issue_pair_check
  import gemini_issue_pkg::*;
#(
  parameter int PTR_W = 3
) (
  input  entry_t           e0,
  input  entry_t           e1,
  input  logic [PTR_W:0]   count,
  output logic             iss0_ok,
  output logic             iss1_ok
);

  localparam logic [PTR_W:0] TWO = (PTR_W+1)'(2);

  logic ctrl0;
  logic ctrl1;
  logic both_ls;
  logic haz;
  logic has_two;
  logic unused_fields;

  assign ctrl0   = is_ctrl(e0);
  assign ctrl1   = is_ctrl(e1);
  assign both_ls = e0.is_ls & e1.is_ls;
  assign haz     = dual_hazard(e0, e1);
  assign has_two = (count >= TWO);

  // a lone branch waits for its delay slot so the pair leaves together
  assign iss0_ok = (count != '0) && !(ctrl0 && !has_two);

  // behind a branch the delay slot always rides along; register hazards in
  // that case are resolved by a one-cycle wait in the parent, not a split
  assign iss1_ok = iss0_ok && has_two && !ctrl1 &&
                   (ctrl0 || (!haz && !both_ls));

  assign unused_fields = ^{e0.pc, e0.inst, e0.imme, e0.op_code, e0.pad,
                           e1.pc, e1.inst, e1.imme, e1.op_code, e1.pad,
                           e1.is_ls ^ e1.is_ls};

endmodule

// File: rtl/issue_queue_ctrl.sv
// rtl/issue_queue_ctrl.sv - dual-issue queue between id1 and the two issue_id2 registers
// clk, rst          : clock, synchronous active-high reset
// flush, stall      : empty the queue / hold all entries
// in0_*, in1_*      : up to two decoded entries per cycle from id1 (in1 younger)
// in_ready          : at least two free entries
// iss0_*, iss1_*    : issue slots; entry is zero when the slot is not valid
// q_count           : current occupancy
module issue_queue_ctrl
  import gemini_issue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall,
  input  logic               in0_valid,
  input  logic [ENTRY_W-1:0] in0_entry,
  input  logic               in1_valid,
  input  logic [ENTRY_W-1:0] in1_entry,
  output logic               in_ready,
  output logic               iss0_valid,
  output logic [ENTRY_W-1:0] iss0_entry,
  output logic               iss1_valid,
  output logic [ENTRY_W-1:0] iss1_entry,
  output logic [PTR_W:0]     q_count
);

  localparam logic [PTR_W-1:0] ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   TWO    = (PTR_W+1)'(2);
  localparam logic [PTR_W:0]   RDY_LIM = (PTR_W+1)'(DEPTH - 2);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             pair_waited;

  entry_t     e0;
  entry_t     e1;
  logic       iss0_ok;
  logic       iss1_ok;
  logic       ctrl_pair_haz;
  logic       hold;
  logic       enq;
  logic [1:0] enq_n;
  logic [1:0] deq_n;

  assign e0 = mem[head];
  assign e1 = mem[head + ONE];

  issue_pair_check #(.PTR_W(PTR_W)) u_pair_check (
    .e0      (e0),
    .e1      (e1),
    .count   (count),
    .iss0_ok (iss0_ok),
    .iss1_ok (iss1_ok)
  );

  // branch with a register hazard against its delay slot: stall both slots
  // for one unstalled cycle, then release the pair together
  assign ctrl_pair_haz = (count >= TWO) && is_ctrl(e0) && dual_hazard(e0, e1);
  assign hold          = ctrl_pair_haz && !pair_waited;

  assign iss0_valid = iss0_ok && !stall && !flush && !hold;
  assign iss1_valid = iss0_valid && iss1_ok;
  assign iss0_entry = iss0_valid ? e0 : '0;
  assign iss1_entry = iss1_valid ? e1 : '0;

  // from registered occupancy only, so it never depends on this cycle's issue
  assign in_ready = (count <= RDY_LIM);
  assign q_count  = count;

  assign enq   = in_ready && in0_valid && !flush && !rst;
  assign enq_n = enq ? (in1_valid ? 2'd2 : 2'd1) : 2'd0;
  assign deq_n = {1'b0, iss0_valid} + {1'b0, iss1_valid};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      pair_waited <= 1'b0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
      if (iss0_valid) begin
        pair_waited <= 1'b0;
      end else if (ctrl_pair_haz && !stall) begin
        pair_waited <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[tail] <= entry_t'(in0_entry);
      if (in1_valid) begin
        mem[tail + ONE] <= entry_t'(in1_entry);
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// tb/tb_issue_queue_ctrl.sv - self-checking bench for issue_queue_ctrl
module tb_issue_queue_ctrl;
  import gemini_issue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               stall;
  logic               in0_valid;
  logic [ENTRY_W-1:0] in0_entry;
  logic               in1_valid;
  logic [ENTRY_W-1:0] in1_entry;
  logic               in_ready;
  logic               iss0_valid;
  logic [ENTRY_W-1:0] iss0_entry;
  logic               iss1_valid;
  logic [ENTRY_W-1:0] iss1_entry;
  logic [PTR_W:0]     q_count;

  int     n_cmp = 0;
  int     n_bad = 0;
  entry_t mq[$];
  bit     waited = 1'b0;

  always #5 clk = ~clk;

  issue_queue_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall      (stall),
    .in0_valid  (in0_valid),
    .in0_entry  (in0_entry),
    .in1_valid  (in1_valid),
    .in1_entry  (in1_entry),
    .in_ready   (in_ready),
    .iss0_valid (iss0_valid),
    .iss0_entry (iss0_entry),
    .iss1_valid (iss1_valid),
    .iss1_entry (iss1_entry),
    .q_count    (q_count)
  );

  // kind: 0 alu, 1 load, 2 store, 3 beq, 4 j, 5 jr, 6 jal (writes dst)
  function automatic entry_t mk(input int kind, input int dst, input int rs, input int rt);
    entry_t e;
    e           = '0;
    e.pc        = $urandom;
    e.inst      = $urandom;
    e.imme      = 16'($urandom);
    e.op_code   = 6'($urandom);
    e.rs        = 5'(rs);
    e.rt        = 5'(rt);
    e.w_reg_dst = 5'(dst);
    case (kind)
      0: e.w_reg_ena = 1'b1;
      1: begin e.is_ls = 1'b1; e.w_reg_ena = 1'b1; end
      2: e.is_ls = 1'b1;
      3: e.is_branch = 1'b1;
      4: e.is_j_imme = 1'b1;
      5: e.is_jr = 1'b1;
      default: begin e.is_j_imme = 1'b1; e.w_reg_ena = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic bit m_jump(entry_t e);
    return e.is_branch || e.is_j_imme || e.is_jr;
  endfunction

  // does b read or rewrite the nonzero register a produces
  function automatic bit m_conflict(entry_t a, entry_t b);
    if (!a.w_reg_ena || a.w_reg_dst == 5'd0) return 1'b0;
    if (a.w_reg_dst == b.rs || a.w_reg_dst == b.rt) return 1'b1;
    return b.w_reg_ena && (b.w_reg_dst == a.w_reg_dst);
  endfunction

  task automatic chk(input string tag, input logic [ENTRY_W-1:0] obs, input logic [ENTRY_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v0, input entry_t d0, input bit v1, input entry_t d1);
    in0_valid = v0;
    in0_entry = d0;
    in1_valid = v1;
    in1_entry = d1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0);
  endtask

  // called at posedge+1 with inputs already set; checks, then advances the model
  task automatic cycle();
    int     n;
    bit     rdy;
    bit     hz;
    bit     ok0;
    bit     ok1;
    entry_t e0;
    entry_t e1;
    n  = mq.size();
    e0 = '0;
    e1 = '0;
    if (n >= 1) e0 = mq[0];
    if (n >= 2) e1 = mq[1];
    rdy = (DEPTH - n) >= 2;
    hz  = (n >= 2) && m_jump(e0) && m_conflict(e0, e1);
    ok0 = (n >= 1) && !stall && !flush && !(m_jump(e0) && n < 2) && !(hz && !waited);
    ok1 = ok0 && (n >= 2) && !m_jump(e1) &&
          (m_jump(e0) || (!m_conflict(e0, e1) && !(e0.is_ls && e1.is_ls)));
    #1;
    chk("q_count", q_count, n);
    chk("in_ready", in_ready, rdy);
    chk("iss0_valid", iss0_valid, ok0);
    chk("iss1_valid", iss1_valid, ok1);
    chk("iss0_entry", iss0_entry, ok0 ? e0 : '0);
    chk("iss1_entry", iss1_entry, ok1 ? e1 : '0);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      waited = 1'b0;
    end else begin
      if (ok0) void'(mq.pop_front());
      if (ok1) void'(mq.pop_front());
      if (ok0) waited = 1'b0;
      else if (hz && !stall) waited = 1'b1;
      if (rdy && in0_valid) begin
        mq.push_back(entry_t'(in0_entry));
        if (in1_valid) mq.push_back(entry_t'(in1_entry));
      end
    end
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    stall = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // independent ALU pair
    drive(1, mk(0, 1, 3, 4), 1, mk(0, 2, 3, 4)); cycle();
    idle(); repeat (2) cycle();

    // RAW pair splits
    drive(1, mk(0, 5, 6, 7), 1, mk(0, 8, 5, 9)); cycle();
    idle(); repeat (3) cycle();

    // two loads serialize
    drive(1, mk(1, 10, 2, 0), 1, mk(1, 11, 3, 0)); cycle();
    idle(); repeat (3) cycle();

    // lone branch waits for its delay slot
    drive(1, mk(3, 0, 1, 2), 0, '0); cycle();
    idle(); repeat (2) cycle();
    drive(1, mk(0, 12, 1, 2), 0, '0); cycle();
    idle(); repeat (2) cycle();

    // jal whose delay slot reads r31: one stall cycle, then the pair together
    drive(1, mk(6, 31, 0, 0), 1, mk(0, 4, 31, 1)); cycle();
    idle(); repeat (3) cycle();

    // fill under stall to 7, one rejected pair, then drain across the wrap
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(0, 1 + 2 * i, 20, 21), 1, mk(0, 2 + 2 * i, 20, 21)); cycle();
    end
    drive(1, mk(0, 7, 20, 21), 0, '0); cycle();
    drive(1, mk(0, 8, 20, 21), 1, mk(0, 9, 20, 21)); cycle();
    stall = 1'b0;
    idle(); repeat (6) cycle();

    // flush at count 5 with a same-cycle enqueue
    stall = 1'b1;
    drive(1, mk(0, 1, 20, 21), 1, mk(0, 2, 20, 21)); cycle();
    drive(1, mk(0, 3, 20, 21), 1, mk(0, 4, 20, 21)); cycle();
    drive(1, mk(0, 5, 20, 21), 0, '0); cycle();
    stall = 1'b0;
    flush = 1'b1;
    drive(1, mk(0, 6, 20, 21), 1, mk(0, 7, 20, 21)); cycle();
    flush = 1'b0;
    idle(); repeat (2) cycle();

    // random traffic
    repeat (500) begin
      flush = ($urandom_range(0, 31) == 0);
      stall = ($urandom_range(0, 4) == 0);
      drive($urandom_range(0, 9) < 7,
            mk($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
            $urandom_range(0, 1) == 1,
            mk($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
      cycle();
    end
    flush = 1'b0;
    stall = 1'b0;
    idle(); repeat (8) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
